// File: rtl/agc_gain_control.sv
`default_nettype none
// ============================================================================
// Module   : agc_gain_control
// Purpose  : Closed-loop AGC. Steps the gain toward a power target with a
//            deadband and waits for settling after each change. Applies the
//            gain to the sample stream through a 2-stage saturating multiply.
// Revision : 1.0 - initial release
// ============================================================================
module agc_gain_control #(
  parameter int SYMBOL_WIDTH  = 16,
  parameter int SYMBOL_FRAC   = 14,
  parameter int GAIN_WIDTH    = 16,
  parameter int GAIN_FRAC     = 12,
  parameter int GAIN_INIT     = 4096,
  parameter int GAIN_MIN      = 64,
  parameter int GAIN_MAX      = 65535,
  parameter int GAIN_STEP     = 64,
  parameter int TARGET_POWER  = 134217728,
  parameter int TOLERANCE     = 8388608,
  parameter int SETTLE_BLOCKS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           est_valid,
  input  logic signed [2*SYMBOL_WIDTH-1:0] est_power,
  input  logic                           new_sample,
  input  logic signed [SYMBOL_WIDTH-1:0] sample,
  output logic                           new_out,
  output logic signed [SYMBOL_WIDTH-1:0] sample_out,
  output logic        [GAIN_WIDTH-1:0]   gain,
  output logic                           locked
);

  localparam int PW    = 2 * SYMBOL_WIDTH;
  localparam int GX    = GAIN_WIDTH + 2;
  localparam int PRODW = SYMBOL_WIDTH + GAIN_WIDTH + 1;
  localparam int CW    = $clog2(SETTLE_BLOCKS + 1);

  localparam logic [1:0] S_TRACK = 2'd0;
  localparam logic [1:0] S_EVAL  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  // Deadband edges, one bit wider than the estimate so the sums cannot wrap.
  localparam logic signed [PW:0] PWR_HI = (PW+1)'(TARGET_POWER + TOLERANCE);
  localparam logic signed [PW:0] PWR_LO = (PW+1)'(TARGET_POWER - TOLERANCE);

  // Gain arithmetic is done two bits wider and signed so step/clamp never wraps.
  localparam logic signed [GX-1:0] G_STEP = GX'(GAIN_STEP);
  localparam logic signed [GX-1:0] G_MIN  = GX'(GAIN_MIN);
  localparam logic signed [GX-1:0] G_MAX  = GX'(GAIN_MAX);
  localparam logic [GAIN_WIDTH-1:0] G_INIT = GAIN_WIDTH'(GAIN_INIT);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_BLOCKS);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  localparam logic signed [PRODW-1:0] S_MAX = PRODW'((1 << (SYMBOL_WIDTH-1)) - 1);
  localparam logic signed [PRODW-1:0] S_MIN = PRODW'(-(1 << (SYMBOL_WIDTH-1)));

  logic [1:0]              state;
  logic [1:0]              state_next;
  logic signed [PW-1:0]    power_q;
  logic signed [PW:0]      power_x;
  logic [CW-1:0]           settle_cnt;
  logic [GAIN_WIDTH-1:0]   gain_next;
  logic                    locked_next;
  logic                    gain_changed;
  logic signed [GX-1:0]    gain_w;
  logic signed [GX-1:0]    gain_up;
  logic signed [GX-1:0]    gain_dn;

  logic                    s1_valid;
  logic signed [PRODW-1:0] prod_d;
  logic signed [PRODW-1:0] prod_q;
  logic signed [PRODW-1:0] prod_shift;
  logic signed [SYMBOL_WIDTH-1:0] sat_val;

  assign power_x      = {power_q[PW-1], power_q};
  assign gain_w       = $signed({2'b00, gain});
  assign gain_up      = gain_w + G_STEP;
  assign gain_dn      = gain_w - G_STEP;
  assign gain_changed = (gain_next != gain);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_TRACK;
    end else if (en) begin
      state <= state_next;
    end
  end

  // Next-state logic: EVAL goes to HOLD only when the gain really moved.
  always_comb begin
    state_next = state;
    case (state)
      S_TRACK: if (est_valid) state_next = S_EVAL;
      S_EVAL:  state_next = gain_changed ? S_HOLD : S_TRACK;
      S_HOLD:  if (est_valid && (settle_cnt <= CNT_ONE)) state_next = S_TRACK;
      default: state_next = S_TRACK;
    endcase
  end

  // Output logic: evaluate the registered estimate against the deadband.
  always_comb begin
    gain_next   = gain;
    locked_next = locked;
    if (state == S_EVAL) begin
      if (power_x > PWR_HI) begin
        gain_next   = (gain_dn < G_MIN) ? G_MIN[GAIN_WIDTH-1:0] : gain_dn[GAIN_WIDTH-1:0];
        locked_next = 1'b0;
      end else if (power_x < PWR_LO) begin
        gain_next   = (gain_up > G_MAX) ? G_MAX[GAIN_WIDTH-1:0] : gain_up[GAIN_WIDTH-1:0];
        locked_next = 1'b0;
      end else begin
        locked_next = 1'b1;
      end
    end
  end

  // Control datapath: gain/locked registers, estimate capture, settle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      gain       <= G_INIT;
      locked     <= 1'b0;
      power_q    <= '0;
      settle_cnt <= '0;
    end else if (en) begin
      gain   <= gain_next;
      locked <= locked_next;
      if (state == S_TRACK && est_valid) begin
        power_q <= est_power;
      end
      if (state == S_EVAL && state_next == S_HOLD) begin
        settle_cnt <= SETTLE_LOAD;
      end else if (state == S_HOLD && est_valid && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - CNT_ONE;
      end
    end
  end

  // Stage-1 product with operands sign/zero-extended to the full product width.
  assign prod_d = $signed({{(GAIN_WIDTH+1){sample[SYMBOL_WIDTH-1]}}, sample})
                * $signed({{(SYMBOL_WIDTH+1){1'b0}}, gain});

  // Stage 1: register the product, sampling the current gain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      prod_q   <= '0;
    end else if (en) begin
      s1_valid <= new_sample;
      if (new_sample) begin
        prod_q <= prod_d;
      end
    end
  end

  // Stage-2 rescale (arithmetic, truncating) and saturation.
  always_comb begin
    prod_shift = prod_q >>> GAIN_FRAC;
    if (prod_shift > S_MAX) begin
      sat_val = S_MAX[SYMBOL_WIDTH-1:0];
    end else if (prod_shift < S_MIN) begin
      sat_val = S_MIN[SYMBOL_WIDTH-1:0];
    end else begin
      sat_val = prod_shift[SYMBOL_WIDTH-1:0];
    end
  end

  // Stage 2: output register; sample_out holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      new_out    <= 1'b0;
      sample_out <= '0;
    end else if (en) begin
      new_out <= s1_valid;
      if (s1_valid) begin
        sample_out <= sat_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_agc_gain_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_agc_gain_control
// Purpose  : Randomized self-checking bench for agc_gain_control against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_agc_gain_control;

  localparam int G_INIT = 4096;
  localparam int G_MIN  = 64;
  localparam int G_MAX  = 65535;
  localparam int G_STEP = 64;
  localparam int P_HI   = 134217728 + 8388608;
  localparam int P_LO   = 134217728 - 8388608;
  localparam int SETTLE = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic               est_valid = 1'b0;
  logic signed [31:0] est_power = '0;
  logic               new_sample = 1'b0;
  logic signed [15:0] sample = '0;
  logic               new_out;
  logic signed [15:0] sample_out;
  logic [15:0]        gain;
  logic               locked;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_gain, m_p, m_skip, m_p1, m_out;
  bit m_locked, m_eval, m_p1v, m_outv;

  always #5 clk = ~clk;

  agc_gain_control dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .est_valid  (est_valid),
    .est_power  (est_power),
    .new_sample (new_sample),
    .sample     (sample),
    .new_out    (new_out),
    .sample_out (sample_out),
    .gain       (gain),
    .locked     (locked)
  );

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int scale_sat(input int s, input int g);
    longint pr;
    pr = (longint'(s) * longint'(g)) >>> 12;
    if (pr > 32767) return 32767;
    if (pr < -32768) return -32768;
    return int'(pr);
  endfunction

  task automatic model_reset();
    m_gain = G_INIT; m_locked = 0; m_eval = 0; m_p = 0; m_skip = 0;
    m_p1v = 0; m_p1 = 0; m_outv = 0; m_out = 0;
  endtask

  // One en-cycle of spec behaviour: samples see the gain in force now;
  // an accepted estimate is judged one cycle later, during which further
  // estimates are ignored; a gain change discards the next SETTLE estimates.
  task automatic model_step();
    int ng;
    if (rst) begin
      model_reset();
    end else if (en) begin
      m_outv = m_p1v;
      if (m_p1v) m_out = m_p1;
      m_p1v = new_sample;
      if (new_sample) m_p1 = scale_sat(int'(sample), m_gain);
      if (m_eval) begin
        ng = m_gain;
        if (m_p > P_HI) begin
          ng = (m_gain - G_STEP < G_MIN) ? G_MIN : m_gain - G_STEP;
          m_locked = 0;
        end else if (m_p < P_LO) begin
          ng = (m_gain + G_STEP > G_MAX) ? G_MAX : m_gain + G_STEP;
          m_locked = 0;
        end else begin
          m_locked = 1;
        end
        if (ng != m_gain) m_skip = SETTLE;
        m_gain = ng;
        m_eval = 0;
      end else if (est_valid) begin
        if (m_skip > 0) m_skip--;
        else begin
          m_p = int'(est_power);
          m_eval = 1;
        end
      end
    end
  endtask

  // mode 0: mixed incl. deadband edges, 1: below target, 2: above target.
  function automatic int pick_power(input int mode);
    if (mode == 1) begin
      if ($urandom_range(3) == 0) return -int'($urandom_range(32'h7FFF_FFFF));
      return int'($urandom_range(P_LO - 1));
    end
    if (mode == 2) return P_HI + 1 + int'($urandom_range(32'h7FFF_FFFF - P_HI - 1));
    case ($urandom_range(7))
      0: return P_HI + 1;
      1: return P_HI;
      2: return P_LO;
      3: return P_LO - 1;
      4: return int'($urandom);
      5: return 134217728;
      6: return int'($urandom_range(32'h2000_0000));
      default: return 0;
    endcase
  endfunction

  function automatic logic signed [15:0] pick_sample();
    case ($urandom_range(5))
      0: return 16'sh7FFF;
      1: return -16'sh8000;
      2: return 16'sh2000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic compare_all();
    check_val("gain", gain, m_gain);
    check_val("locked", locked, m_locked);
    check_val("new_out", new_out, m_outv);
    check_val("sample_out", sample_out, m_out);
  endtask

  task automatic run_phase(input int ncyc, input int mode, input int en_pct,
                           input int est_pct, input int rst_pm);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      rst        = (int'($urandom_range(999)) < rst_pm);
      en         = (int'($urandom_range(99)) < en_pct);
      est_valid  = (int'($urandom_range(99)) < est_pct);
      est_power  = pick_power(mode);
      new_sample = $urandom_range(1) == 1;
      sample     = pick_sample();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    model_step();
    @(posedge clk); #1;
    check_val("reset_gain", gain, G_INIT);
    check_val("reset_locked", locked, 0);
    check_val("reset_new_out", new_out, 0);
    check_val("reset_sample_out", sample_out, 0);

    run_phase(1500, 0, 90, 30, 0);
    run_phase(10, 0, 0, 100, 0);
    run_phase(4500, 1, 100, 100, 0);
    check_val("gain_at_max", gain, G_MAX);
    run_phase(4600, 2, 100, 100, 0);
    check_val("gain_at_min", gain, G_MIN);
    run_phase(10, 0, 0, 100, 0);
    run_phase(2000, 0, 85, 40, 5);

    @(negedge clk);
    rst = 1'b0; en = 1'b0; est_valid = 1'b0; new_sample = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
